reload_counter: RTL and testbench



---
 rtl/reload_counter.sv | 97 +++++++++
 tb/tb_reload_counter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/reload_counter.sv
// Reloadable terminal counter: counts prescaled ticks up or down between 0 and a
// programmable reload value, pulsing overflow at each terminal event.
module reload_counter #(
  parameter int WIDTH       = 16,
  parameter int RESET_VALUE = 9,
  parameter int PRESCALE    = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enb,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dir,
  input  logic             one_shot,
  output logic [WIDTH-1:0] count,
  output logic             overflow,
  output logic             done,
  output logic             busy
);

  localparam int PCW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic {RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] rl_q, rl_d;
  logic [PCW-1:0]   pc_q, pc_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;
  logic             tick;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] restart_val;

  assign tick        = enb && (state_q == RUN) && (pc_q == PCW'(PRESCALE - 1));
  assign term_val    = dir ? rl_q : '0;
  assign restart_val = dir ? '0 : rl_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      count_q <= WIDTH'(RESET_VALUE);
      rl_q    <= WIDTH'(RESET_VALUE);
      pc_q    <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      rl_q    <= rl_d;
      pc_q    <= pc_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    rl_d    = rl_q;
    pc_d    = pc_q;
    ovf_d   = 1'b0;
    done_d  = done_q;
    if (load) begin
      rl_d    = load_value;
      count_d = dir ? '0 : load_value;
      pc_d    = '0;
      done_d  = 1'b0;
      state_d = RUN;
    end else if (state_q == RUN && enb) begin
      if (!tick) begin
        pc_d = pc_q + PCW'(1);
      end else begin
        pc_d = '0;
        if (count_q == term_val) begin
          ovf_d = 1'b1;
          if (one_shot) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            count_d = restart_val;
          end
        end else if (dir) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
  end

  assign count    = count_q;
  assign overflow = ovf_q;
  assign done     = done_q;
  assign busy     = (state_q == RUN);

endmodule

// File: tb/tb_reload_counter.sv
// Scoreboard bench for reload_counter: two instances (PRESCALE 1 and 4) share stimulus;
// a behavioural model queues expected outputs and a monitor compares each cycle.
module tb_reload_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enb = 1'b0;
  logic        load = 1'b0;
  logic [15:0] lv = '0;
  logic        dir = 1'b0;
  logic        os = 1'b0;

  logic [15:0] cnt0;
  logic [7:0]  cnt1;
  logic        ovf0, dn0, bz0, ovf1, dn1, bz1;

  always #5 clk = ~clk;

  reload_counter #(.WIDTH(16), .RESET_VALUE(9), .PRESCALE(1)) dut0 (
    .clk(clk), .rst(rst), .enb(enb), .load(load), .load_value(lv),
    .dir(dir), .one_shot(os), .count(cnt0), .overflow(ovf0), .done(dn0), .busy(bz0)
  );

  reload_counter #(.WIDTH(8), .RESET_VALUE(9), .PRESCALE(4)) dut1 (
    .clk(clk), .rst(rst), .enb(enb), .load(load), .load_value(lv[7:0]),
    .dir(dir), .one_shot(os), .count(cnt1), .overflow(ovf1), .done(dn1), .busy(bz1)
  );

  typedef struct packed {
    logic [1:0][15:0] cnt;
    logic [1:0]       ovf;
    logic [1:0]       dn;
    logic [1:0]       bz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state, one slot per instance
  int unsigned m_cnt[2];
  int unsigned m_rl[2];
  int          m_pc[2];
  bit          m_run[2];
  bit          m_dn[2];
  bit          m_ovf[2];
  int          m_p[2]    = '{1, 4};
  int unsigned m_mask[2] = '{32'hFFFF, 32'hFF};

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_rl[i] = 9; m_cnt[i] = 9; m_pc[i] = 0;
        m_ovf[i] = 0; m_dn[i] = 0; m_run[i] = 1;
      end else if (load) begin
        m_rl[i]  = lv & m_mask[i];
        m_cnt[i] = dir ? 0 : m_rl[i];
        m_pc[i] = 0; m_ovf[i] = 0; m_dn[i] = 0; m_run[i] = 1;
      end else begin
        m_ovf[i] = 0;
        if (m_run[i] && enb) begin
          if (m_pc[i] < m_p[i] - 1) begin
            m_pc[i]++;
          end else begin
            m_pc[i] = 0;
            if (m_cnt[i] == (dir ? m_rl[i] : 0)) begin
              m_ovf[i] = 1;
              if (os) begin
                m_dn[i] = 1; m_run[i] = 0;
              end else begin
                m_cnt[i] = dir ? 0 : m_rl[i];
              end
            end else begin
              m_cnt[i] = dir ? m_cnt[i] + 1 : m_cnt[i] - 1;
            end
          end
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit l, input int v, input bit e, input bit d, input bit o);
    exp_t x;
    @(negedge clk);
    rst = r; load = l; lv = 16'(v); enb = e; dir = d; os = o;
    model_step();
    for (int i = 0; i < 2; i++) begin
      x.cnt[i] = 16'(m_cnt[i]);
      x.ovf[i] = m_ovf[i];
      x.dn[i]  = m_dn[i];
      x.bz[i]  = m_run[i];
    end
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
    end
  endtask

  // Monitor: outputs are presented every cycle, compare against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cnt0", int'(cnt0), int'(e.cnt[0]));
        chk("ovf0", int'(ovf0), int'(e.ovf[0]));
        chk("done0", int'(dn0), int'(e.dn[0]));
        chk("busy0", int'(bz0), int'(e.bz[0]));
        chk("cnt1", int'(cnt1), int'(e.cnt[1]));
        chk("ovf1", int'(ovf1), int'(e.ovf[1]));
        chk("done1", int'(dn1), int'(e.dn[1]));
        chk("busy1", int'(bz1), int'(e.bz[1]));
      end
    end
  end

  initial begin
    bit d, o;
    int guard;
    // Reset, then free-running down count
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 25; k++) drive(0, 0, 0, 1, 0, 0);
    // One-shot up count to 3
    drive(0, 1, 3, 0, 1, 1);
    for (int k = 0; k < 24; k++) drive(0, 0, 0, 1, 1, 1);
    // Toggled enable, reload 2, down
    drive(0, 1, 2, 0, 0, 0);
    for (int k = 0; k < 40; k++) drive(0, 0, 0, k[0] == 1'b0, 0, 0);
    // Load coinciding with a terminal tick on the PRESCALE=1 instance
    drive(1, 0, 0, 0, 0, 0);
    guard = 0;
    while (m_cnt[0] != 0 && guard < 50) begin drive(0, 0, 0, 1, 0, 0); guard++; end
    drive(0, 1, 5, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    // Reset while in DONE
    drive(0, 1, 1, 0, 1, 1);
    for (int k = 0; k < 12; k++) drive(0, 0, 0, 1, 1, 1);
    drive(0, 0, 0, 1, 1, 0);
    drive(1, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 0);
    // Mid-run direction flip at count 4
    guard = 0;
    while (m_cnt[0] != 4 && guard < 50) begin drive(0, 0, 0, 1, 0, 0); guard++; end
    for (int k = 0; k < 14; k++) drive(0, 0, 0, 1, 1, 0);
    // Reload zero, auto-reload
    drive(0, 1, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) drive(0, 0, 0, 1, k[1], 0);
    // Randomized traffic
    d = 0; o = 0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(19) == 0) d = ~d;
      if ($urandom_range(14) == 0) o = ~o;
      drive($urandom_range(149) == 0, $urandom_range(24) == 0,
            ($urandom_range(9) == 0) ? int'($urandom_range(255)) : int'($urandom_range(12)),
            $urandom_range(9) < 7, d, o);
    end
    drive(0, 0, 0, 0, d, o);
    @(posedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
